expu_row_ctrl: RTL and testbench

// Valid/ready flow controller that sits upstream of one expu_row and drives its enable_i/clear_i.

---
 rtl/expu_row_ctrl.sv | 87 ++++++++
 tb/tb_expu_row_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expu_row_ctrl.sv
// expu_row_ctrl: valid/ready flow controller for one expu_row.
// Carries a valid bit and a sideband tag per row register stage, drives the
// row's per-stage load enables and clear, and collapses bubbles so the row
// keeps accepting one operand per cycle under downstream back-pressure.
// Stage k mirrors row register reg_data[k+1]; stage NUM_REGS-1 is the output.
module expu_row_ctrl #(
    parameter int NUM_REGS  = 2,
    parameter int TAG_WIDTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [TAG_WIDTH-1:0]              tag_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [TAG_WIDTH-1:0]              tag_o,
    output logic [NUM_REGS-1:0]               enable_o,
    output logic                              clear_o,
    output logic [$clog2(NUM_REGS+1)-1:0]     occupancy_o
);

    localparam int OCC_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0]  v;
    logic [TAG_WIDTH-1:0] tag    [NUM_REGS];
    logic [TAG_WIDTH-1:0] in_tag [NUM_REGS];
    logic [NUM_REGS-1:0]  in_v;
    logic [NUM_REGS:0]    rdy;
    logic                 chain;
    logic                 flush;
    logic                 in_xfer;
    logic                 out_xfer;

    assign flush    = rst_i | clear_i;
    assign clear_o  = flush;
    assign valid_o  = v[NUM_REGS-1];
    assign tag_o    = tag[NUM_REGS-1];
    assign ready_o  = rdy[0] & ~flush;
    assign enable_o = in_v & rdy[NUM_REGS-1:0] & {NUM_REGS{~flush}};
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    // Readiness chain from ready_i back to stage 0; a stage can take a new
    // operand if it is empty or everything above it can move. Built through a
    // running accumulator so the vector never reads its own bits.
    always_comb begin
        chain          = ready_i;
        rdy[NUM_REGS]  = chain;
        for (int unsigned j = 0; j < NUM_REGS; j++) begin
            chain                 = ~v[NUM_REGS-1-j] | chain;
            rdy[NUM_REGS-1-j]     = chain;
        end
    end

    // Per-stage input valid and tag: stage 0 takes the upstream operand,
    // every other stage takes the contents of the stage below it.
    always_comb begin
        in_v[0]   = valid_i;
        in_tag[0] = tag_i;
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            in_v[k]   = v[k-1];
            in_tag[k] = tag[k-1];
        end
    end

    // Valid/tag state and occupancy; flush drops every in-flight operand.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            v           <= '0;
            occupancy_o <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                tag[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                v[k] <= enable_o[k] | (v[k] & ~rdy[k+1]);
                if (enable_o[k]) begin
                    tag[k] <= in_tag[k];
                end
            end
            occupancy_o <= occupancy_o + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

endmodule

// File: tb/tb_expu_row_ctrl.sv
// Testbench for expu_row_ctrl with NUM_REGS=3, TAG_WIDTH=8.
// Reference model: an ordered list of in-flight operands, each with a
// position 0..N-1; an operand moves up one position when any free slot
// exists above it, and the oldest leaves when it sits at the top and
// ready_i is high.
module tb_expu_row_ctrl;

    localparam int N  = 3;
    localparam int TW = 8;
    localparam int OW = $clog2(N + 1);
    localparam int VW = 2 + TW + N + 1 + OW;

    logic          clk = 1'b0;
    logic          rst, clr, vin, rin;
    logic [TW-1:0] tin;
    logic          ready_o, valid_o, clear_o;
    logic [TW-1:0] tag_o;
    logic [N-1:0]  enable_o;
    logic [OW-1:0] occupancy_o;

    expu_row_ctrl #(.NUM_REGS(N), .TAG_WIDTH(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clr),
        .valid_i     (vin),
        .ready_o     (ready_o),
        .tag_i       (tin),
        .valid_o     (valid_o),
        .ready_i     (rin),
        .tag_o       (tag_o),
        .enable_o    (enable_o),
        .clear_o     (clear_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: oldest operand at index 0
    logic [TW-1:0] q_tag [$];
    int            q_pos [$];

    // model expectations for the current cycle
    logic          e_ready, e_valid, e_clear;
    logic [TW-1:0] e_tag;
    logic [N-1:0]  e_en;
    int            e_occ;
    int            e_pop;

    function automatic void model_eval();
        int sz;
        sz      = q_tag.size();
        e_clear = rst | clr;
        e_occ   = sz;
        e_valid = (sz > 0) && (q_pos[0] == N - 1);
        e_tag   = e_valid ? q_tag[0] : '0;
        e_pop   = (e_valid && rin && !rst && !clr) ? 1 : 0;
        e_ready = ((sz - e_pop) < N) && !rst && !clr;
        e_en    = '0;
        if (!rst && !clr) begin
            for (int j = e_pop; j < sz; j++) begin
                if (q_pos[j] < N - 1 - (j - e_pop)) e_en[q_pos[j] + 1] = 1'b1;
            end
            if (vin && e_ready) e_en[0] = 1'b1;
        end
    endfunction

    function automatic void model_commit();
        if (rst || clr) begin
            q_tag.delete();
            q_pos.delete();
            return;
        end
        if (e_pop == 1) begin
            void'(q_tag.pop_front());
            void'(q_pos.pop_front());
        end
        for (int j = 0; j < q_pos.size(); j++) begin
            if (q_pos[j] < N - 1 - j) q_pos[j] = q_pos[j] + 1;
        end
        if (vin && e_ready) begin
            q_tag.push_back(tin);
            q_pos.push_back(0);
        end
    endfunction

    function automatic logic [VW-1:0] pack_obs();
        return {ready_o, valid_o, (valid_o ? tag_o : {TW{1'b0}}), enable_o, clear_o, occupancy_o};
    endfunction

    function automatic logic [VW-1:0] pack_exp();
        return {e_ready, e_valid, (e_valid ? e_tag : {TW{1'b0}}), e_en, e_clear, OW'(e_occ)};
    endfunction

    // apply inputs just after the clock edge, let them settle, evaluate model
    task automatic drive(input logic r, input logic c, input logic v, input logic rd,
                         input logic [TW-1:0] t);
        rst = r; clr = c; vin = v; rin = rd; tin = t;
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 0, 8'h00);
        advance();
        drive(1, 0, 1, 1, 8'h55);
        checks++;
        if (ready_o !== 1'b0 || clear_o !== 1'b1 || enable_o !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold got rdy=%b clr=%b en=%b exp rdy=0 clr=1 en=000", ready_o, clear_o, enable_o);
        end
        advance();
        drive(0, 0, 0, 0, 8'h00);
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || tag_o !== 8'h00 || occupancy_o !== 2'd0 || clear_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b vld=%b tag=%h occ=%0d clr=%b exp 1 0 00 0 0",
                     ready_o, valid_o, tag_o, occupancy_o, clear_o);
        end
        advance();
    endtask

    task automatic test_stream();
        logic [TW-1:0] want;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, (c < 4), 1, 8'(8'h10 + c));
            checks++;
            if (pack_obs() !== pack_exp()) begin
                errors++;
                $display("FAIL stream_model c=%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            if (c >= 3 && c <= 6) begin
                want = 8'(8'h10 + c - 3);
                checks++;
                if (valid_o !== 1'b1 || tag_o !== want) begin
                    errors++;
                    $display("FAIL stream_out c=%0d got vld=%b tag=%h exp vld=1 tag=%h", c, valid_o, tag_o, want);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (enable_o !== 3'b111) begin
                    errors++;
                    $display("FAIL stream_enable c=%0d got %b exp 111", c, enable_o);
                end
            end
            if (c == 7) begin
                checks++;
                if (valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_drained got vld=%b exp 0", valid_o);
                end
            end
            advance();
        end
    endtask

    // leaves the pipe full with 0x20,0x21,0x22
    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 1, 0, 8'(8'h20 + c));
            checks++;
            if (pack_obs() !== pack_exp()) begin
                errors++;
                $display("FAIL bp_model c=%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            if (c >= 3) begin
                checks++;
                if (ready_o !== 1'b0 || occupancy_o !== 2'd3 || enable_o !== 3'b000 ||
                    valid_o !== 1'b1 || tag_o !== 8'h20) begin
                    errors++;
                    $display("FAIL bp_full c=%0d got rdy=%b occ=%0d en=%b vld=%b tag=%h exp 0 3 000 1 20",
                             c, ready_o, occupancy_o, enable_o, valid_o, tag_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] order [6];
        order = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
        for (int c = 0; c < 9; c++) begin
            drive(0, 0, (c < 6), 1, 8'(8'h30 + c));
            checks++;
            if (pack_obs() !== pack_exp()) begin
                errors++;
                $display("FAIL b2b_model c=%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            if (c < 6) begin
                checks++;
                if (ready_o !== 1'b1 || occupancy_o !== 2'd3 || valid_o !== 1'b1 || tag_o !== order[c]) begin
                    errors++;
                    $display("FAIL b2b_flow c=%0d got rdy=%b occ=%0d vld=%b tag=%h exp 1 3 1 %h",
                             c, ready_o, occupancy_o, valid_o, tag_o, order[c]);
                end
            end
            advance();
        end
    endtask

    task automatic test_bubble();
        logic       vv;
        logic [7:0] tt;
        for (int c = 0; c < 9; c++) begin
            vv = (c == 0) || (c == 2);
            tt = (c == 0) ? 8'hA1 : 8'hA2;
            drive(0, 0, vv, (c >= 5), tt);
            checks++;
            if (pack_obs() !== pack_exp()) begin
                errors++;
                $display("FAIL bubble_model c=%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            if (c == 3) begin
                checks++;
                if (enable_o !== 3'b010) begin
                    errors++;
                    $display("FAIL bubble_collapse got en=%b exp 010", enable_o);
                end
            end
            if (c == 4) begin
                checks++;
                if (valid_o !== 1'b1 || tag_o !== 8'hA1 || occupancy_o !== 2'd2 || enable_o !== 3'b000) begin
                    errors++;
                    $display("FAIL bubble_state got vld=%b tag=%h occ=%0d en=%b exp 1 a1 2 000",
                             valid_o, tag_o, occupancy_o, enable_o);
                end
            end
            if (c == 6) begin
                checks++;
                if (valid_o !== 1'b1 || tag_o !== 8'hA2) begin
                    errors++;
                    $display("FAIL bubble_second got vld=%b tag=%h exp 1 a2", valid_o, tag_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_clear();
        for (int c = 0; c < 11; c++) begin
            drive(0, (c == 5), (c <= 6), 1, (c == 6) ? 8'h77 : 8'(8'h40 + c));
            checks++;
            if (pack_obs() !== pack_exp()) begin
                errors++;
                $display("FAIL clear_model c=%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            if (c == 5) begin
                checks++;
                if (clear_o !== 1'b1 || ready_o !== 1'b0 || enable_o !== 3'b000 ||
                    valid_o !== 1'b1 || tag_o !== 8'h42) begin
                    errors++;
                    $display("FAIL clear_cycle got clr=%b rdy=%b en=%b vld=%b tag=%h exp 1 0 000 1 42",
                             clear_o, ready_o, enable_o, valid_o, tag_o);
                end
            end
            if (c >= 6 && c <= 8) begin
                checks++;
                if (valid_o !== 1'b0 || (c == 6 && occupancy_o !== 2'd0)) begin
                    errors++;
                    $display("FAIL clear_flushed c=%0d got vld=%b occ=%0d exp vld=0", c, valid_o, occupancy_o);
                end
            end
            if (c == 9) begin
                checks++;
                if (valid_o !== 1'b1 || tag_o !== 8'h77) begin
                    errors++;
                    $display("FAIL clear_restart got vld=%b tag=%h exp 1 77", valid_o, tag_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 8; c++) begin
            drive((c == 2), 0, 1'b1 && (c <= 3), (c >= 3), (c == 3) ? 8'h5A : 8'(8'h60 + c));
            checks++;
            if (pack_obs() !== pack_exp()) begin
                errors++;
                $display("FAIL rstmid_model c=%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            if (c == 2) begin
                checks++;
                if (ready_o !== 1'b0 || clear_o !== 1'b1 || enable_o !== 3'b000) begin
                    errors++;
                    $display("FAIL rstmid_hold got rdy=%b clr=%b en=%b exp 0 1 000", ready_o, clear_o, enable_o);
                end
            end
            if (c == 3) begin
                checks++;
                if (ready_o !== 1'b1 || valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
                    errors++;
                    $display("FAIL rstmid_release got rdy=%b vld=%b occ=%0d exp 1 0 0", ready_o, valid_o, occupancy_o);
                end
            end
            if (c == 6) begin
                checks++;
                if (valid_o !== 1'b1 || tag_o !== 8'h5A) begin
                    errors++;
                    $display("FAIL rstmid_latency got vld=%b tag=%h exp 1 5a", valid_o, tag_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
                  8'($urandom_range(0, 255)));
            checks++;
            if (pack_obs() !== pack_exp()) begin
                errors++;
                $display("FAIL random_model c=%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; vin = 1'b0; rin = 1'b0; tin = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_bubble();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
